// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_driver
// Brief    : Dual 50 Hz servo PWM generator with valid/ready command capture,
//            per-frame slew limiting, command watchdog and right-wheel mirroring.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_driver #(
    parameter int CLKS_PER_US    = 65,
    parameter int FRAME_US       = 20000,
    parameter int NEUTRAL_US     = 1500,
    parameter int US_PER_STEP    = 4,
    parameter int MIN_US         = 1000,
    parameter int MAX_US         = 2000,
    parameter int SLEW_STEP      = 8,
    parameter int TIMEOUT_FRAMES = 25,
    parameter int RIGHT_INVERT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] cmd_left,
    input  logic [7:0] cmd_right,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic [7:0] cur_left,
    output logic [7:0] cur_right,
    output logic       timed_out
);

    localparam int c_PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int c_UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int c_WW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    localparam logic [c_PW-1:0]     c_PRESC_MAX = c_PW'(CLKS_PER_US - 1);
    localparam logic [c_UW-1:0]     c_US_MAX    = c_UW'(FRAME_US - 1);
    localparam logic [c_WW-1:0]     c_WD_MAX    = c_WW'(TIMEOUT_FRAMES);
    localparam logic signed [12:0]  c_NEUTRAL   = 13'(NEUTRAL_US);
    localparam logic signed [12:0]  c_STEP      = 13'(US_PER_STEP);
    localparam logic signed [12:0]  c_MIN       = 13'(MIN_US);
    localparam logic signed [12:0]  c_MAX       = 13'(MAX_US);
    localparam logic signed [8:0]   c_SLEW      = 9'(SLEW_STEP);

    logic [c_PW-1:0] r_presc;
    logic [c_UW-1:0] r_us;
    logic [c_WW-1:0] r_wd;
    logic            r_pend_full;
    logic [7:0]      r_pend_l, r_pend_r;
    logic [7:0]      r_tgt_l, r_tgt_r;
    logic [7:0]      r_cur_l, r_cur_r;
    logic [12:0]     r_width_l, r_width_r;
    logic            r_timed_out;
    logic            r_pwm_l, r_pwm_r;

    logic            w_tick, w_frame_start, w_accept, w_wd_expire;
    logic [c_WW-1:0] w_wd_inc;
    logic [7:0]      w_cap_l, w_cap_r;
    logic [7:0]      w_tgt_l, w_tgt_r;
    logic [7:0]      w_cur_l, w_cur_r;

    // Move cur toward tgt by at most SLEW_STEP; a zero step means jump directly.
    function automatic logic [7:0] slew_next(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] diff;
        diff = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
        if (SLEW_STEP == 0 || (diff <= c_SLEW && diff >= -c_SLEW))
            slew_next = tgt;
        else if (diff > c_SLEW)
            slew_next = cur + c_SLEW[7:0];
        else
            slew_next = cur - c_SLEW[7:0];
    endfunction

    function automatic logic [12:0] width_of(input logic [7:0] cur, input logic invert);
        logic signed [12:0] cur_x, offs, raw;
        cur_x = $signed({{5{cur[7]}}, cur});
        offs  = cur_x * c_STEP;
        raw   = invert ? (c_NEUTRAL - offs) : (c_NEUTRAL + offs);
        if (raw < c_MIN)
            width_of = c_MIN;
        else if (raw > c_MAX)
            width_of = c_MAX;
        else
            width_of = raw;
    endfunction

    always_comb begin
        w_tick        = (r_presc == c_PRESC_MAX);
        w_frame_start = w_tick && (r_us == c_US_MAX);
        cmd_ready     = enable && !reset && !r_pend_full;
        w_accept      = cmd_valid && cmd_ready;
        w_cap_l       = (cmd_left  == 8'h80) ? 8'h81 : cmd_left;
        w_cap_r       = (cmd_right == 8'h80) ? 8'h81 : cmd_right;
        w_wd_inc      = (r_wd == c_WD_MAX) ? r_wd : r_wd + c_WW'(1);
        w_wd_expire   = !r_pend_full && (w_wd_inc == c_WD_MAX);
        // Target in force after this frame's load or watchdog override.
        w_tgt_l       = r_pend_full ? r_pend_l : (w_wd_expire ? 8'd0 : r_tgt_l);
        w_tgt_r       = r_pend_full ? r_pend_r : (w_wd_expire ? 8'd0 : r_tgt_r);
        w_cur_l       = slew_next(r_cur_l, w_tgt_l);
        w_cur_r       = slew_next(r_cur_r, w_tgt_r);
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_presc     <= '0;
            r_us        <= '0;
            r_wd        <= '0;
            r_pend_full <= 1'b0;
            r_pend_l    <= 8'd0;
            r_pend_r    <= 8'd0;
            r_tgt_l     <= 8'd0;
            r_tgt_r     <= 8'd0;
            r_cur_l     <= 8'd0;
            r_cur_r     <= 8'd0;
            r_width_l   <= 13'(NEUTRAL_US);
            r_width_r   <= 13'(NEUTRAL_US);
            r_timed_out <= 1'b0;
            r_pwm_l     <= 1'b0;
            r_pwm_r     <= 1'b0;
        end else begin
            r_pwm_l <= (32'(r_us) < 32'(r_width_l));
            r_pwm_r <= (32'(r_us) < 32'(r_width_r));

            if (w_tick) begin
                r_presc <= '0;
                r_us    <= w_frame_start ? '0 : r_us + c_UW'(1);
            end else begin
                r_presc <= r_presc + c_PW'(1);
            end

            // Widths change only here, the same edge us_count wraps to 0.
            if (w_frame_start) begin
                r_tgt_l   <= w_tgt_l;
                r_tgt_r   <= w_tgt_r;
                r_cur_l   <= w_cur_l;
                r_cur_r   <= w_cur_r;
                r_width_l <= width_of(w_cur_l, 1'b0);
                r_width_r <= width_of(w_cur_r, RIGHT_INVERT != 0);
                if (r_pend_full) begin
                    r_pend_full <= 1'b0;
                end else begin
                    r_wd <= w_wd_inc;
                    if (w_wd_expire)
                        r_timed_out <= 1'b1;
                end
            end

            if (w_accept) begin
                r_pend_full <= 1'b1;
                r_pend_l    <= w_cap_l;
                r_pend_r    <= w_cap_r;
                r_wd        <= '0;
                r_timed_out <= 1'b0;
            end
        end
    end

    assign pwm_left  = r_pwm_l;
    assign pwm_right = r_pwm_r;
    assign cur_left  = r_cur_l;
    assign cur_right = r_cur_r;
    assign timed_out = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_driver
// Brief    : Self-checking bench for servo_pwm_driver against a frame-level
//            behavioural model, plus directed literal pulse/ramp checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_driver;

    localparam int CLKS    = 3;
    localparam int FRAME   = 250;
    localparam int NEUTRAL = 150;
    localparam int STEP    = 1;
    localparam int WMIN    = 100;
    localparam int WMAX    = 200;
    localparam int SLEW    = 8;
    localparam int TOUT    = 3;
    localparam int INV     = 1;
    localparam int P       = CLKS * FRAME;

    logic       clk = 1'b0;
    logic       reset, enable, cmd_valid;
    logic [7:0] cmd_left, cmd_right;
    logic       cmd_ready, pwm_left, pwm_right, timed_out;
    logic [7:0] cur_left, cur_right;

    int n_checks = 0;
    int n_fail   = 0;

    servo_pwm_driver #(
        .CLKS_PER_US(CLKS), .FRAME_US(FRAME), .NEUTRAL_US(NEUTRAL),
        .US_PER_STEP(STEP), .MIN_US(WMIN), .MAX_US(WMAX), .SLEW_STEP(SLEW),
        .TIMEOUT_FRAMES(TOUT), .RIGHT_INVERT(INV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .pwm_left(pwm_left), .pwm_right(pwm_right),
        .cur_left(cur_left), .cur_right(cur_right), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int sat8(input logic [7:0] v);
        int s;
        s = $signed(v);
        return (s == -128) ? -127 : s;
    endfunction

    function automatic int slew(input int c, input int t);
        if (SLEW == 0 || (t - c <= SLEW && c - t <= SLEW)) return t;
        return (t > c) ? c + SLEW : c - SLEW;
    endfunction

    function automatic int clampw(input int w);
        return (w < WMIN) ? WMIN : ((w > WMAX) ? WMAX : w);
    endfunction

    int m_k, m_pend, m_pl, m_pr, m_tl, m_tr, m_cl, m_cr, m_wl, m_wr, m_wd, m_to;
    int m_pwl, m_pwr;
    bit m_init = 1'b0;

    // k counts enabled edges since the last clear; frame boundaries fall at k % P == 0.
    always @(posedge clk) begin
        bit acc;
        m_init = 1'b1;
        if (reset || !enable) begin
            m_k = 0; m_pend = 0; m_pl = 0; m_pr = 0; m_tl = 0; m_tr = 0;
            m_cl = 0; m_cr = 0; m_wl = NEUTRAL; m_wr = NEUTRAL; m_wd = 0; m_to = 0;
            m_pwl = 0; m_pwr = 0;
        end else begin
            m_k++;
            m_pwl = (((m_k - 1) % P) < m_wl * CLKS) ? 1 : 0;
            m_pwr = (((m_k - 1) % P) < m_wr * CLKS) ? 1 : 0;
            acc = cmd_valid && (m_pend == 0);
            if (m_k % P == 0) begin
                if (m_pend != 0) begin
                    m_tl = m_pl; m_tr = m_pr; m_pend = 0;
                end else begin
                    if (m_wd < TOUT) m_wd++;
                    if (m_wd == TOUT) begin
                        m_to = 1; m_tl = 0; m_tr = 0;
                    end
                end
                m_cl = slew(m_cl, m_tl);
                m_cr = slew(m_cr, m_tr);
                m_wl = clampw(NEUTRAL + m_cl * STEP);
                m_wr = clampw((INV != 0) ? NEUTRAL - m_cr * STEP : NEUTRAL + m_cr * STEP);
            end
            if (acc) begin
                m_pend = 1; m_pl = sat8(cmd_left); m_pr = sat8(cmd_right);
                m_wd = 0; m_to = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("pwm_left",  pwm_left,  m_pwl);
            check("pwm_right", pwm_right, m_pwr);
            check("cur_left",  $signed(cur_left),  m_cl);
            check("cur_right", $signed(cur_right), m_cr);
            check("timed_out", timed_out, m_to);
            check("cmd_ready", cmd_ready, enable && !reset && (m_pend == 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input int l, input int r);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_left  = 8'(l);
        cmd_right = 8'(r);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail_now("send_cmd_ready");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        int   n;
        prev = pwm_left;
        n    = 0;
        ok   = 1'b0;
        while (n < 2 * P) begin
            @(negedge clk);
            n++;
            if (!prev && pwm_left) begin
                ok = 1'b1;
                break;
            end
            prev = pwm_left;
        end
        if (!ok) fail_now("wait_rise");
    endtask

    task automatic measure(output int hl, output int hr);
        bit ok;
        wait_rise(ok);
        hl = 0;
        hr = 0;
        for (int i = 0; i < P; i++) begin
            hl += int'(pwm_left);
            hr += int'(pwm_right);
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        int  hl, hr, pth;
        bit  ok, acc;
        int  exp_ramp [5] = '{8, 16, 20, 20, 20};

        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_left = 8'd0; cmd_right = 8'd0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;

        // Idle neutral output.
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_cur_left", $signed(cur_left), 0);
        measure(hl, hr);
        check("neutral_high_left", hl, 450);
        check("neutral_high_right", hr, 450);

        // Slew ramp to (20,20): mirrored right wheel.
        for (int i = 0; i < 5; i++) begin
            send_cmd(20, 20);
            wait_rise(ok);
            check("ramp_cur_left", $signed(cur_left), exp_ramp[i]);
            check("ramp_cur_right", $signed(cur_right), exp_ramp[i]);
        end
        measure(hl, hr);
        check("ramp_high_left", hl, 510);
        check("ramp_high_right", hr, 390);

        // Saturation of -128 and width clamping.
        send_cmd(-128, 127);
        wait_rise(ok);
        check("sat_first_left", $signed(cur_left), 12);
        check("sat_first_right", $signed(cur_right), 28);
        for (int i = 0; i < 20; i++) begin
            send_cmd(-128, 127);
            wait_rise(ok);
        end
        check("sat_cur_left", $signed(cur_left), -127);
        check("sat_cur_right", $signed(cur_right), 127);
        measure(hl, hr);
        check("clamp_high_left", hl, 300);
        check("clamp_high_right", hr, 300);

        // Back-to-back pairs: second waits for the pending buffer to drain.
        send_cmd(10, -10);
        @(negedge clk);
        check("b2b_ready_low", cmd_ready, 0);
        send_cmd(-30, 30);
        wait_rise(ok);
        check("b2b_cur_left", $signed(cur_left), -111);
        check("b2b_cur_right", $signed(cur_right), 111);

        // Watchdog.
        repeat (4 * P + 4) @(negedge clk);
        check("watchdog_set", timed_out, 1);
        send_cmd(0, 0);
        @(negedge clk);
        check("watchdog_clear", timed_out, 0);

        // Enable drop mid-pulse.
        wait_rise(ok);
        repeat (100) @(negedge clk);
        @(posedge clk); #1 enable = 1'b0;
        @(negedge clk);
        check("disable_ready", cmd_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("disable_pwm", pwm_left, 0);
        check("disable_cur", $signed(cur_left), 0);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 enable = 1'b1;
        measure(hl, hr);
        check("reenable_high_left", hl, 450);
        check("reenable_high_right", hr, 450);

        // Randomized traffic with held data, sporadic resets and disables.
        pth = 0;
        for (int c = 0; c < 15 * P; c++) begin
            if (c % P == 0) begin
                case ($urandom_range(0, 3))
                    0:       pth = 0;
                    1:       pth = 2;
                    2:       pth = 50;
                    default: pth = 500;
                endcase
            end
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (!cmd_valid || acc) begin
                cmd_valid = ($urandom_range(0, 999) < pth);
                cmd_left  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
                cmd_right = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            end
            reset = ($urandom_range(0, 4999) == 0);
            if (enable && $urandom_range(0, 5999) == 0)
                enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0)
                enable = 1'b1;
        end
        cmd_valid = 1'b0;
        reset     = 1'b0;
        enable    = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
